// File: rtl/dm_pkg.sv
// Shared types for the data-memory access controller.
// Op codes, FSM states and op-class helpers.
package dm_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE_WR,
    RESP
  } state_e;

  // one bit per op code, indexed by op
  localparam logic [7:0] IS_STORE_M = 8'hE0;
  localparam logic [7:0] IS_HALF_M  = 8'h46;
  localparam logic [7:0] IS_BYTE_M  = 8'h98;

  function automatic logic is_store(op_e op);
    return IS_STORE_M[op];
  endfunction

  function automatic logic is_half(op_e op);
    return IS_HALF_M[op];
  endfunction

  function automatic logic is_byte(op_e op);
    return IS_BYTE_M[op];
  endfunction

  function automatic logic is_word(op_e op);
    return !IS_HALF_M[op] && !IS_BYTE_M[op];
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/response bus from the MEM stage and
// the word-only data memory port.
interface dm_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_op,
    output req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid, req_op,
    input  req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata,
    output resp_err
  );
endinterface

interface dm_mem_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_addr, mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dm_access_ctrl_lane_unit.sv
// Lane extraction/extension for loads and
// lane merge for sub-word stores.
module dm_lane_unit
  import dm_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  logic [31:0] ins;

  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];

    load_data = '0;
    unique case (op)
      LW:      load_data = word;
      LH:      load_data = {{16{h[15]}}, h};
      LHU:     load_data = {16'h0, h};
      LB:      load_data = {{24{b[7]}}, b};
      LBU:     load_data = {24'h0, b};
      default: load_data = '0;
    endcase

    // replicate store data over all lanes, keep only the chosen one
    mask = '1;
    ins  = wdata;
    unique case (1'b1)
      is_byte(op): begin
        mask = 32'hFF << {lane, 3'b000};
        ins  = {4{wdata[7:0]}};
      end
      is_half(op): begin
        mask = lane[1] ? 32'hFFFF_0000
                       : 32'h0000_FFFF;
        ins  = {2{wdata[15:0]}};
      end
      default: begin
        mask = '1;
        ins  = wdata;
      end
    endcase
    merged = (word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: sub-word RMW
// stores, extended loads, align/range errors.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int DM_BYTES = 12288,
  parameter int ADDR_W   = 32
) (
  input  logic  clk,
  input  logic  RESET,
  dm_req_if.slave  req,
  dm_mem_if.master mem
);

  state_e state_q, state_d;

  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       merge_q;
  logic              err_q;

  op_e         op_in;
  logic        misal;
  logic        oor;
  logic        acc_err;
  logic        accept;
  logic [31:0] lane_word;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign op_in = op_e'(req.req_op);

  always_comb begin
    misal = (is_half(op_in) && req.req_addr[0])
         || (is_word(op_in)
             && (req.req_addr[1:0] != 2'b00));
    oor = req.req_addr > ADDR_W'(DM_BYTES - 1);
    acc_err = misal || oor;
  end

  // the merge step works on the captured word,
  // not on the live memory output
  assign lane_word = (state_q == MERGE_WR)
                   ? merge_q : mem.mem_rdata;

  dm_lane_unit u_lane (
    .op        (op_q),
    .lane      (addr_q[1:0]),
    .word      (lane_word),
    .wdata     (wdata_q),
    .load_data (load_ext),
    .merged    (merged)
  );

  assign mem.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    req.req_ready  = 1'b0;
    req.resp_valid = 1'b0;
    req.resp_rdata = '0;
    req.resp_err   = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) begin
          accept  = 1'b1;
          state_d = acc_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (op_q == SW) begin
          mem.mem_we    = 1'b1;
          mem.mem_wdata = wdata_q;
          state_d       = RESP;
        end else if (is_store(op_q)) begin
          state_d = MERGE_WR;
        end else begin
          state_d = RESP;
        end
      end
      MERGE_WR: begin
        mem.mem_we    = 1'b1;
        mem.mem_wdata = merged;
        state_d       = RESP;
      end
      RESP: begin
        req.resp_valid = 1'b1;
        req.resp_rdata = rdata_q;
        req.resp_err   = err_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      op_q    <= LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= op_in;
      addr_q  <= req.req_addr;
      wdata_q <= req.req_wdata;
      rdata_q <= '0;
      err_q   <= acc_err;
    end else if (state_q == ACCESS) begin
      if (is_store(op_q)) merge_q <= mem.mem_rdata;
      else                rdata_q <= load_ext;
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomised + directed bench for dm_access_ctrl
// against a transaction-level memory model.
module tb_dm_access_ctrl;
  import dm_pkg::*;

  localparam int DMB = 12288;

  logic clk;
  logic RESET;

  dm_req_if rq ();
  dm_mem_if mi ();

  dm_access_ctrl #(
    .DM_BYTES (DMB),
    .ADDR_W   (32)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .req   (rq),
    .mem   (mi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit [31:0] mem     [3072];
  bit [31:0] ref_mem [3072];

  assign mi.mem_rdata = (mi.mem_addr < DMB)
                      ? mem[mi.mem_addr[13:2]] : 32'h0;

  always @(posedge clk)
    if (mi.mem_we && mi.mem_addr < DMB)
      mem[mi.mem_addr[13:2]] <= mi.mem_wdata;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h",
               tag, got, exp);
    end
  endtask

  function automatic bit m_err(op_e op,
                               logic [31:0] a);
    bit h = (op == LH || op == LHU || op == SH);
    bit w = (op == LW || op == SW);
    return (h && a % 2 != 0) || (w && a % 4 != 0)
        || (a >= DMB);
  endfunction

  function automatic logic [31:0] m_load(op_e op,
                                         logic [31:0] a);
    logic [31:0] w   = ref_mem[a / 4];
    int          sh  = 8 * (a % 4);
    int          sh2 = 16 * ((a / 2) % 2);
    logic [31:0] v;
    case (op)
      LW: v = w;
      LB, LBU: begin
        v = (w >> sh) & 32'hFF;
        if (op == LB && v >= 128) v = v + 32'hFFFF_FF00;
      end
      LH, LHU: begin
        v = (w >> sh2) & 32'hFFFF;
        if (op == LH && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_store(op_e op,
                                          logic [31:0] a,
                                          logic [31:0] wd);
    logic [31:0] w   = ref_mem[a / 4];
    int          sh  = 8 * (a % 4);
    int          sh2 = 16 * ((a / 2) % 2);
    case (op)
      SB: return (w & ~(32'hFF << sh))
               | ((wd & 32'hFF) << sh);
      SH: return (w & ~(32'hFFFF << sh2))
               | ((wd & 32'hFFFF) << sh2);
      default: return wd;
    endcase
  endfunction

  task automatic run(input op_e op,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     output logic [31:0] rd);
    bit          e_err = m_err(op, a);
    bit          st    = (op == SW || op == SH || op == SB);
    int          e_lat;
    int          e_nw;
    int          e_wc;
    logic [31:0] e_rd = 0;
    logic [31:0] e_wd = 0;
    int          nw = 0;
    int          wc = 0;
    logic [31:0] wa = 0;
    logic [31:0] wv = 0;
    bit          got = 0;
    int          lat = 0;
    logic        re = 0;
    rd = 0;
    e_lat = e_err ? 1 : (st && op != SW) ? 3 : 2;
    e_nw  = (e_err || !st) ? 0 : 1;
    e_wc  = (op == SW) ? 1 : 2;
    if (!e_err && !st) e_rd = m_load(op, a);
    if (!e_err && st)  e_wd = m_store(op, a, wd);
    @(negedge clk);
    chk("ready_idle", rq.req_ready, 1);
    rq.req_valid = 1;
    rq.req_op    = op;
    rq.req_addr  = a;
    rq.req_wdata = wd;
    @(posedge clk);
    #1 rq.req_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mi.mem_we) begin
        nw++;
        wc = k;
        wa = mi.mem_addr;
        wv = mi.mem_wdata;
      end
      if (rq.resp_valid) begin
        got = 1;
        lat = k;
        rd  = rq.resp_rdata;
        re  = rq.resp_err;
        break;
      end
    end
    if (!got) begin
      chk("resp_timeout", 0, 1);
    end else begin
      chk("latency", lat, e_lat);
      chk("err", re, e_err);
      chk("rdata", rd, e_rd);
      chk("n_writes", nw, e_nw);
      if (e_nw == 1) begin
        chk("wr_cycle", wc, e_wc);
        chk("wr_addr", wa, a & ~32'h3);
        chk("wr_data", wv, e_wd);
      end
    end
    if (!e_err && st) ref_mem[a / 4] = e_wd;
  endtask

  logic [31:0] rd;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] e_busy;
  int          npulse;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rq.req_valid = 0;
    rq.req_op    = 0;
    rq.req_addr  = 0;
    rq.req_wdata = 0;
    RESET = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rq.req_ready, 1);
    chk("rst_rvalid", rq.resp_valid, 0);
    chk("rst_rdata", rq.resp_rdata, 0);
    chk("rst_err", rq.resp_err, 0);
    chk("rst_we", mi.mem_we, 0);
    chk("rst_addr", mi.mem_addr, 0);
    chk("rst_wdata", mi.mem_wdata, 0);
    RESET = 0;

    run(SW, 32'h10, 32'hDEADBEEF, rd);
    run(LW, 32'h10, 0, rd);
    chk("sw_readback", rd, 32'hDEADBEEF);

    run(SW, 32'h20, 32'h11223344, rd);
    run(SB, 32'h22, 32'h000000AB, rd);
    run(LW, 32'h20, 0, rd);
    chk("sb_word", rd, 32'h11AB3344);
    run(LB, 32'h22, 0, rd);
    chk("lb", rd, 32'hFFFFFFAB);
    run(LBU, 32'h22, 0, rd);
    chk("lbu", rd, 32'h000000AB);

    run(SH, 32'h32, 32'h00008001, rd);
    run(LW, 32'h30, 0, rd);
    chk("sh_word", rd, 32'h80010000);
    run(LH, 32'h32, 0, rd);
    chk("lh", rd, 32'hFFFF8001);
    run(LHU, 32'h32, 0, rd);
    chk("lhu", rd, 32'h00008001);

    run(LW, 32'h0006, 0, rd);
    run(SH, 32'h0041, 32'h1234, rd);
    run(SW, 32'h3000, 32'hA5A5A5A5, rd);
    run(SW, 32'h2FFC, 32'h0BADF00D, rd);
    run(LW, 32'h2FFC, 0, rd);
    chk("edge_lw", rd, 32'h0BADF00D);
    run(LW, 32'h0004, 0, rd);
    chk("err_no_write", rd, 0);

    // request held valid across an SB, next one queued behind it
    wd = $urandom;
    e_busy = m_store(SB, 32'h23, wd);
    @(negedge clk);
    rq.req_valid = 1;
    rq.req_op    = SB;
    rq.req_addr  = 32'h23;
    rq.req_wdata = wd;
    npulse = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 5) rq.req_valid = 0;
      if (rq.resp_valid) npulse++;
      if (cyc <= 3) chk("busy_ready", rq.req_ready, 0);
      if (cyc == 3) begin
        rq.req_op   = LW;
        rq.req_addr = 32'h20;
      end
      if (cyc == 4) chk("busy_ready4", rq.req_ready, 1);
      if (cyc == 6) begin
        chk("busy_resp2", rq.resp_valid, 1);
        chk("busy_rdata", rq.resp_rdata, e_busy);
      end
    end
    chk("busy_pulses", npulse, 2);
    ref_mem[32'h20 / 4] = e_busy;

    // reset lands in the ACCESS cycle of an SB
    run(SW, 32'h24, 32'hCAFEF00D, rd);
    @(negedge clk);
    rq.req_valid = 1;
    rq.req_op    = SB;
    rq.req_addr  = 32'h25;
    rq.req_wdata = 32'h77;
    @(posedge clk);
    #1;
    rq.req_valid = 0;
    RESET = 1;
    @(negedge clk);
    chk("rst_mid_we", mi.mem_we, 0);
    @(posedge clk);
    #1 RESET = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_ready", rq.req_ready, 1);
      chk("abort_we", mi.mem_we, 0);
      chk("abort_resp", rq.resp_valid, 0);
    end
    run(LW, 32'h24, 0, rd);
    chk("abort_word", rd, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      op_e op = op_e'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: a = 32'h2FF0 + $urandom_range(0, 19);
        1: a = $urandom;
        default: a = $urandom_range(0, 255);
      endcase
      run(op, a, $urandom, rd);
    end

    for (int i = 0; i < 64; i++)
      chk("final_mem", mem[i], ref_mem[i]);
    chk("final_edge", mem[3071], ref_mem[3071]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
